// File: rtl/bm_dag2_log_drv.sv
// -----------------------------------------------------------------------------
// bm_dag2_log_drv
//   Self-checking stimulus driver for a small two-output logic DUT.
//   A 16-bit Galois LFSR (mask 16'hB400) produces one vector per RUN cycle.
//   The driver predicts both DUT results, compares them at their fixed
//   latencies and counts mismatches.
//
//   FSM: IDLE -> RUN (num_vec cycles) -> DRAIN (2 cycles) -> DONE.
//   start is accepted only in IDLE or DONE.
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset
//   start          in   one-cycle run request
//   num_vec[7:0]   in   vectors per run, sampled on accepted start
//   seed[15:0]     in   LFSR seed, sampled on accepted start (0 loads 1)
//   dut_out0       in   DUT wide result (BITS), checked 2 cycles after vector
//   dut_out1       in   DUT single-bit result, checked 1 cycle after vector
//   a_in, b_in     out  registered operands (BITS)
//   c_in, d_in     out  registered single-bit stimulus
//   busy           out  high in RUN and DRAIN
//   done           out  high in DONE
//   pass           out  done and no mismatches
//   err_cnt[7:0]   out  mismatch count, saturating at 255
//
// Optional feature (macro BM_DAG2_FIRST_ERR_EN):
//   first_err_vld  out  a mismatch has been seen in this run
//   first_err_idx  out  vector index k of the earliest mismatch
// -----------------------------------------------------------------------------
module bm_dag2_log_drv #(
  parameter int unsigned BITS = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [7:0]      num_vec,
  input  logic [15:0]     seed,
  input  logic [BITS-1:0] dut_out0,
  input  logic            dut_out1,
  output logic [BITS-1:0] a_in,
  output logic [BITS-1:0] b_in,
  output logic            c_in,
  output logic            d_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_cnt
`ifdef BM_DAG2_FIRST_ERR_EN
  ,
  output logic            first_err_vld,
  output logic [7:0]      first_err_idx
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Control state
  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      nvec_q, nvec_d;
  logic            drain_q, drain_d;
  logic            accept;

  // Registered stimulus
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic            c_q, c_d;
  logic            d_q, d_d;

  // Compare pipeline: stage 1 holds vector k during cycle k+1,
  // stage 2 holds the out0 prediction for vector k during cycle k+2.
  logic            p1_vld_q;
  logic            p1_first_q;
  logic [BITS-1:0] p1_a_q;
  logic [BITS-1:0] p1_b_q;
  logic            p1_cd_q;
  logic [BITS-1:0] hist_ab_q;
  logic            p2_vld_q;
  logic [BITS-1:0] p2_exp0_q;
  logic [BITS-1:0] exp0_now;
  logic            mis0;
  logic            mis1;

  logic [7:0]      err_q, err_d;
  logic [8:0]      err_sum;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    nvec_d  = nvec_q;
    drain_d = drain_q;
    accept  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept = 1'b1;
          nvec_d = num_vec;
          cnt_d  = '0;
          if (num_vec == 8'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            lfsr_d  = (seed == 16'h0000) ? 16'h0001 : seed;
          end
        end
      end
      S_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (cnt_q == nvec_q - 8'd1) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stimulus registers track the LFSR state that will be current next cycle,
  // so in RUN cycle k the outputs reflect LFSR state L_k.
  always_comb begin
    a_d = '0;
    b_d = '0;
    c_d = 1'b0;
    d_d = 1'b0;
    if (state_d == S_RUN) begin
      a_d = lfsr_d[BITS-1:0];
      b_d = lfsr_d[2*BITS-1:BITS];
      c_d = lfsr_d[2*BITS];
      d_d = lfsr_d[2*BITS+1];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  // hist_ab_q holds a[k-1]&b[k-1] while stage 1 holds vector k.
  always_comb begin
    exp0_now = (p1_a_q & p1_b_q) & (p1_a_q ^ hist_ab_q);
    mis1     = p1_vld_q & (dut_out1 != p1_cd_q);
    mis0     = p2_vld_q & (dut_out0 != p2_exp0_q);
    err_sum  = {1'b0, err_q} + {8'd0, mis0} + {8'd0, mis1};
    if (accept) begin
      err_d = '0;
    end else if (err_sum[8]) begin
      err_d = '1;
    end else begin
      err_d = err_sum[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 16'h0001;
      cnt_q      <= '0;
      nvec_q     <= '0;
      drain_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      d_q        <= 1'b0;
      err_q      <= '0;
      p1_vld_q   <= 1'b0;
      p1_first_q <= 1'b0;
      p1_a_q     <= '0;
      p1_b_q     <= '0;
      p1_cd_q    <= 1'b0;
      hist_ab_q  <= '0;
      p2_vld_q   <= 1'b0;
      p2_exp0_q  <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      nvec_q     <= nvec_d;
      drain_q    <= drain_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      d_q        <= d_d;
      err_q      <= err_d;
      p1_vld_q   <= (state_q == S_RUN);
      p1_first_q <= (cnt_q == 8'd0);
      p1_a_q     <= a_q;
      p1_b_q     <= b_q;
      p1_cd_q    <= c_q & d_q;
      if (p1_vld_q) begin
        hist_ab_q <= p1_a_q & p1_b_q;
      end
      // Vector 0 has no predecessor, so its out0 is never checked.
      p2_vld_q   <= p1_vld_q & ~p1_first_q;
      p2_exp0_q  <= exp0_now;
    end
  end

`ifdef BM_DAG2_FIRST_ERR_EN
  logic [7:0] p1_idx_q;
  logic [7:0] p2_idx_q;
  logic       fe_vld_q;
  logic [7:0] fe_idx_q;

  // A same-cycle tie between the two checks records the out1 index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1_idx_q <= '0;
      p2_idx_q <= '0;
      fe_vld_q <= 1'b0;
      fe_idx_q <= '0;
    end else begin
      p1_idx_q <= cnt_q;
      p2_idx_q <= p1_idx_q;
      if (accept) begin
        fe_vld_q <= 1'b0;
        fe_idx_q <= '0;
      end else if (!fe_vld_q) begin
        if (mis1) begin
          fe_vld_q <= 1'b1;
          fe_idx_q <= p1_idx_q;
        end else if (mis0) begin
          fe_vld_q <= 1'b1;
          fe_idx_q <= p2_idx_q;
        end
      end
    end
  end

  assign first_err_vld = fe_vld_q;
  assign first_err_idx = fe_idx_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign a_in    = a_q;
  assign b_in    = b_q;
  assign c_in    = c_q;
  assign d_in    = d_q;
  assign busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign pass    = (state_q == S_DONE) && (err_q == 8'd0);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_bm_dag2_log_drv.sv
// -----------------------------------------------------------------------------
// Testbench for bm_dag2_log_drv (BITS = 2). A loopback model of the DUT under
// check feeds dut_out0/dut_out1; mode0/mode1 select golden, stuck or inverted.
// -----------------------------------------------------------------------------
module tb_bm_dag2_log_drv;
  localparam int unsigned B = 2;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [7:0]   num_vec;
  logic [15:0]  seed;
  logic [B-1:0] dut_out0;
  logic         dut_out1;
  logic [B-1:0] a_in, b_in;
  logic         c_in, d_in;
  logic         busy, done, pass;
  logic [7:0]   err_cnt;
`ifdef BM_DAG2_FIRST_ERR_EN
  logic         first_err_vld;
  logic [7:0]   first_err_idx;
`endif

  bm_dag2_log_drv #(.BITS(B)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .num_vec  (num_vec),
    .seed     (seed),
    .dut_out0 (dut_out0),
    .dut_out1 (dut_out1),
    .a_in     (a_in),
    .b_in     (b_in),
    .c_in     (c_in),
    .d_in     (d_in),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt)
`ifdef BM_DAG2_FIRST_ERR_EN
    ,
    .first_err_vld (first_err_vld),
    .first_err_idx (first_err_idx)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Loopback model of the logic under check: out1 one cycle late,
  // out0 two cycles late.
  logic [B-1:0] m_prev_ab, m_s1, m_out0;
  logic         m_out1;
  logic [1:0]   mode0, mode1;   // 0 golden, 1 stuck, 2 inverted

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_prev_ab <= '0;
      m_s1      <= '0;
      m_out0    <= '0;
      m_out1    <= 1'b0;
    end else begin
      m_out1    <= c_in & d_in;
      m_prev_ab <= a_in & b_in;
      m_s1      <= (a_in & b_in) & (a_in ^ m_prev_ab);
      m_out0    <= m_s1;
    end
  end

  assign dut_out1 = (mode1 == 2'd0) ? m_out1 : (mode1 == 2'd1) ? 1'b0 : ~m_out1;
  assign dut_out0 = (mode0 == 2'd0) ? m_out0 : (mode0 == 2'd1) ? '1 : ~m_out0;

  int n_assert;
  int n_fail;

  // Model and observed vector streams of the last run
  logic [B-1:0] va [0:255];
  logic [B-1:0] vb [0:255];
  logic         vc [0:255];
  logic         vd [0:255];
  logic [B-1:0] oa [0:255];
  logic [B-1:0] ob [0:255];
  logic         ocd [0:255];

  function automatic logic [15:0] step(input logic [15:0] s);
    logic [15:0] r;
    r = {1'b0, s[15:1]};
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a run from a negedge; returns the number of busy cycles.
  task automatic run(input logic [7:0] nv, input logic [15:0] sd, output int bcyc);
    logic [15:0] l;
    int bad;
    l = (sd == 16'h0000) ? 16'h0001 : sd;
    bad = 0;
    bcyc = 0;
    num_vec = nv;
    seed = sd;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (busy === 1'b1 && bcyc < 600) begin
      if (bcyc < int'(nv)) begin
        va[bcyc] = l[B-1:0];
        vb[bcyc] = l[2*B-1:B];
        vc[bcyc] = l[2*B];
        vd[bcyc] = l[2*B+1];
        oa[bcyc] = a_in;
        ob[bcyc] = b_in;
        ocd[bcyc] = c_in & d_in;
        if ({d_in, c_in, b_in, a_in} !== {l[2*B+1], l[2*B], l[2*B-1:B], l[B-1:0]})
          bad++;
        l = step(l);
      end else if ({a_in, b_in, c_in, d_in} !== '0) begin
        bad++;
      end
      bcyc++;
      @(negedge clock);
    end
    check("stream", bad, 0);
  endtask

  initial begin
    int bc;
    int exp_cnt;
    int exp_idx;
    logic [15:0] l;
    logic [B-1:0] e0;

    n_assert = 0;
    n_fail = 0;
    reset_n = 1'b0;
    start = 1'b0;
    num_vec = '0;
    seed = '0;
    mode0 = 2'd0;
    mode1 = 2'd0;

    // Reset with clock running
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_stim", {a_in, b_in, c_in, d_in}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Golden run, 20 vectors
    run(8'd20, 16'hACE1, bc);
    check("golden_busy_cycles", bc, 22);
    check("golden_done", done, 1);
    check("golden_pass", pass, 1);
    check("golden_err", err_cnt, 0);
    check("done_stim_zero", {a_in, b_in, c_in, d_in}, 0);
    // Hand-derived vectors: L0=ACE1, L1=E270, L2=7138
    check("k0_ab", {oa[0], ob[0]}, 4'b0100);
    check("k0_cd", ocd[0], 0);
    check("k1_ab", {oa[1], ob[1]}, 4'b0000);
    check("k1_cd", ocd[1], 1);
    check("k2_ab", {oa[2], ob[2]}, 4'b0010);

    // out1 tied low; started directly from DONE
    mode1 = 2'd1;
    run(8'd20, 16'hACE1, bc);
    exp_cnt = 0;
    for (int k = 0; k < 20; k++) exp_cnt += int'(vc[k] & vd[k]);
    check("tie0_busy_cycles", bc, 22);
    check("tie0_err", err_cnt, exp_cnt);
    check("tie0_pass", pass, (exp_cnt == 0) ? 1 : 0);
    check("tie0_done", done, 1);
    mode1 = 2'd0;

    // num_vec = 0: done next cycle, err cleared, busy never high
    num_vec = 8'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("nv0_done", done, 1);
    check("nv0_pass", pass, 1);
    check("nv0_busy", busy, 0);
    check("nv0_err", err_cnt, 0);
    @(negedge clock);
    check("nv0_busy2", busy, 0);

    // Reset during vector 5 of 20
    num_vec = 8'd20;
    seed = 16'hACE1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    l = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      l = step(l);
      @(negedge clock);
    end
    check("k5_stim", {d_in, c_in, b_in, a_in}, {l[2*B+1], l[2*B], l[2*B-1:B], l[B-1:0]});
    #2 reset_n = 1'b0;
    #1;
    check("midrst_outputs", {busy, done, pass, a_in, b_in, c_in, d_in, err_cnt}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("midrst_no_done", {busy, done, pass}, 0);
    run(8'd20, 16'hACE1, bc);
    check("rerun_busy_cycles", bc, 22);
    check("rerun_k0_ab", {oa[0], ob[0]}, 4'b0100);
    check("rerun_pass", pass, 1);

    // Both results inverted, 3 vectors: out1 wrong 3x, out0 wrong for k=1,2
    mode0 = 2'd2;
    mode1 = 2'd2;
    run(8'd3, 16'h1234, bc);
    check("inv3_busy_cycles", bc, 5);
    check("inv3_err", err_cnt, 5);
    check("inv3_pass", pass, 0);

    // Saturation: 255 + 254 mismatches clamp to 255
    run(8'd255, 16'h0000, bc);
    check("sat_busy_cycles", bc, 257);
    check("sat_err", err_cnt, 255);
    check("sat_pass", pass, 0);
    mode0 = 2'd0;
    mode1 = 2'd0;

`ifdef BM_DAG2_FIRST_ERR_EN
    // out0 stuck at all-ones
    mode0 = 2'd1;
    run(8'd20, 16'hACE1, bc);
    exp_idx = 0;
    for (int k = 19; k >= 1; k--) begin
      e0 = (va[k] & vb[k]) & (va[k] ^ (va[k-1] & vb[k-1]));
      if (e0 != '1) exp_idx = k;
    end
    check("fe_vld", first_err_vld, 1);
    check("fe_idx", first_err_idx, exp_idx);
    mode0 = 2'd0;
    run(8'd20, 16'hACE1, bc);
    check("fe_cleared", first_err_vld, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
